// File: rtl/bht_gshare.sv
// Gshare branch history table: banked saturating counters indexed by PC^GHR.
// Ports: clk_i/rst_i/flush_i, vpc_i -> pred_*, update_* trains, ready_o, ghr_o.
module bht_gshare #(
  parameter int VLEN            = 64,
  parameter int INSTR_PER_FETCH = 2,
  parameter int NR_ENTRIES      = 1024,
  parameter int CTR_BITS        = 2,
  parameter int HIST_BITS       = 8,
  parameter int ROW_ADDR_OFFSET = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic [VLEN-1:0]            vpc_i,
  input  logic                       update_valid_i,
  input  logic [VLEN-1:0]            update_pc_i,
  input  logic                       update_taken_i,
  output logic                       ready_o,
  output logic [INSTR_PER_FETCH-1:0] pred_valid_o,
  output logic [INSTR_PER_FETCH-1:0] pred_taken_o,
  output logic [HIST_BITS-1:0]       ghr_o
);

  localparam int ROWS      = NR_ENTRIES / INSTR_PER_FETCH;
  localparam int ROW_BITS  = $clog2(ROWS);
  localparam int LANE_BITS = $clog2(INSTR_PER_FETCH);
  localparam int LW        = (LANE_BITS > 0) ? LANE_BITS : 1;
  localparam int ROW_LSB   = ROW_ADDR_OFFSET + LANE_BITS;

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_WNT =
    {1'b0, {(CTR_BITS-1){1'b1}}};
  localparam logic [ROW_BITS-1:0] LAST_ROW =
    ROW_BITS'(ROWS - 1);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e                state_q, state_d;
  logic [ROW_BITS-1:0]   init_cnt_q, init_cnt_d;
  logic [HIST_BITS-1:0]  ghr_q, ghr_d;
  logic [HIST_BITS-1:0]  ghr_shift;
  logic [ROW_BITS-1:0]   hist_idx;
  logic [ROW_BITS-1:0]   pred_idx;
  logic [ROW_BITS-1:0]   upd_idx;
  logic [LW-1:0]         upd_lane;
  logic                  init_we;
  logic                  upd_we;
  logic                  restart;

  // Fold the GHR onto the row index width (truncate or zero-extend).
  if (HIST_BITS >= ROW_BITS) begin : g_hist_trunc
    assign hist_idx = ghr_q[ROW_BITS-1:0];
  end else begin : g_hist_ext
    assign hist_idx = {{(ROW_BITS-HIST_BITS){1'b0}}, ghr_q};
  end

  if (HIST_BITS == 1) begin : g_ghr1
    assign ghr_shift = update_taken_i;
  end else begin : g_ghrn
    assign ghr_shift = {ghr_q[HIST_BITS-2:0], update_taken_i};
  end

  if (LANE_BITS > 0) begin : g_lane
    assign upd_lane = update_pc_i[ROW_ADDR_OFFSET +: LW];
  end else begin : g_nolane
    assign upd_lane = '0;
  end

  assign pred_idx = vpc_i[ROW_LSB +: ROW_BITS] ^ hist_idx;
  assign upd_idx  = update_pc_i[ROW_LSB +: ROW_BITS] ^ hist_idx;

  assign restart = rst_i | flush_i;
  assign init_we = (state_q == S_INIT) & ~restart;
  assign upd_we  = (state_q == S_RUN) & update_valid_i & ~restart;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      ghr_q      <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      ghr_q      <= ghr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    ghr_d      = ghr_q;
    if (restart) begin
      state_d    = S_INIT;
      init_cnt_d = '0;
      ghr_d      = '0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          init_cnt_d = init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_ROW) begin
            state_d    = S_RUN;
            init_cnt_d = '0;
          end
        end
        S_RUN: begin
          if (update_valid_i) ghr_d = ghr_shift;
        end
        default: state_d = S_INIT;
      endcase
    end
  end

  always_comb begin
    ready_o      = (state_q == S_RUN);
    pred_valid_o = {INSTR_PER_FETCH{ready_o}};
    ghr_o        = ghr_q;
  end

  for (genvar b = 0; b < INSTR_PER_FETCH; b++) begin : g_bank
    logic [CTR_BITS-1:0] ctr_q [ROWS];
    logic [CTR_BITS-1:0] upd_old;
    logic [CTR_BITS-1:0] upd_new;
    logic                hit;

    assign upd_old = ctr_q[upd_idx];
    assign hit     = upd_we & (upd_lane == LW'(b));

    always_comb begin
      upd_new = upd_old;
      if (update_taken_i) begin
        if (upd_old != CTR_MAX) upd_new = upd_old + CTR_BITS'(1);
      end else if (upd_old != '0) begin
        upd_new = upd_old - CTR_BITS'(1);
      end
    end

    always_ff @(posedge clk_i) begin
      if (init_we) begin
        ctr_q[init_cnt_q] <= CTR_WNT;
      end else if (hit) begin
        ctr_q[upd_idx] <= upd_new;
      end
    end

    assign pred_taken_o[b] = ready_o & ctr_q[pred_idx][CTR_BITS-1];
  end

endmodule

// File: tb/tb_bht_gshare.sv
// Randomised and directed bench for bht_gshare.
// Reference model: per-lane counter arrays with arithmetic gshare hashing.
module tb_bht_gshare;
  localparam int VLEN = 64;
  localparam int IPF  = 2;
  localparam int NR   = 16;
  localparam int CB   = 2;
  localparam int HB   = 4;
  localparam int RAO  = 1;
  localparam int ROWS = 8;

  logic            clk = 1'b0;
  logic            rst_i = 1'b0;
  logic            flush_i = 1'b0;
  logic [VLEN-1:0] vpc_i = '0;
  logic            update_valid_i = 1'b0;
  logic [VLEN-1:0] update_pc_i = '0;
  logic            update_taken_i = 1'b0;
  logic            ready_o;
  logic [IPF-1:0]  pred_valid_o;
  logic [IPF-1:0]  pred_taken_o;
  logic [HB-1:0]   ghr_o;

  int n_cmp = 0;
  int n_bad = 0;

  int m_ctr [IPF][ROWS];
  int m_ghr = 0;
  bit m_ready = 0;
  int m_init_left = 0;

  always #5 clk = ~clk;

  bht_gshare #(
    .VLEN(VLEN), .INSTR_PER_FETCH(IPF), .NR_ENTRIES(NR),
    .CTR_BITS(CB), .HIST_BITS(HB), .ROW_ADDR_OFFSET(RAO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .vpc_i(vpc_i), .update_valid_i(update_valid_i),
    .update_pc_i(update_pc_i), .update_taken_i(update_taken_i),
    .ready_o(ready_o), .pred_valid_o(pred_valid_o),
    .pred_taken_o(pred_taken_o), .ghr_o(ghr_o)
  );

  function automatic int m_row(logic [VLEN-1:0] pc);
    return int'((pc >> (RAO + 1)) % ROWS);
  endfunction

  function automatic int m_lane(logic [VLEN-1:0] pc);
    return int'((pc >> RAO) % IPF);
  endfunction

  function automatic logic [IPF-1:0] m_pred(logic [VLEN-1:0] pc);
    logic [IPF-1:0] r;
    int idx;
    r = '0;
    if (!m_ready) return r;
    idx = m_row(pc) ^ (m_ghr % ROWS);
    for (int l = 0; l < IPF; l++) r[l] = (m_ctr[l][idx] >= 2);
    return r;
  endfunction

  // Drive one cycle of control inputs and advance the model at the edge.
  task automatic tick(input bit r, input bit f, input bit uv,
                      input logic [VLEN-1:0] upc, input bit ut);
    int idx, ln;
    rst_i = r; flush_i = f; update_valid_i = uv;
    update_pc_i = upc; update_taken_i = ut;
    @(posedge clk);
    if (r || f) begin
      m_ghr = 0; m_ready = 0; m_init_left = ROWS;
      for (int l = 0; l < IPF; l++)
        for (int k = 0; k < ROWS; k++) m_ctr[l][k] = 1;
    end else if (!m_ready) begin
      m_init_left--;
      if (m_init_left == 0) m_ready = 1;
    end else if (uv) begin
      idx = m_row(upc) ^ (m_ghr % ROWS);
      ln = m_lane(upc);
      if (ut && m_ctr[ln][idx] < 3) m_ctr[ln][idx]++;
      else if (!ut && m_ctr[ln][idx] > 0) m_ctr[ln][idx]--;
      m_ghr = ((m_ghr << 1) | int'(ut)) % 16;
    end
    #1;
    rst_i = 0; flush_i = 0; update_valid_i = 0;
  endtask

  task automatic do_reset();
    tick(1, 0, 0, '0, 0);
    for (int i = 0; i < 20 && !m_ready; i++) tick(0, 0, 0, '0, 0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1, 0, 0, '0, 0);
      vpc_i = VLEN'($urandom_range(0, 255)); #1;
      n_cmp++;
      if (ready_o !== 1'b0 || ghr_o !== 4'h0 || pred_taken_o !== 2'b00
          || pred_valid_o !== 2'b00) begin
        n_bad++;
        $display("FAIL reset_hold: rdy=%b ghr=%h pt=%b pv=%b want 0",
                 ready_o, ghr_o, pred_taken_o, pred_valid_o);
      end
    end
    for (int i = 0; i < 10; i++) begin
      tick(0, 0, 0, '0, 0);
      vpc_i = VLEN'($urandom_range(0, 255)); #1;
      n_cmp++;
      if (ready_o !== (i >= 7) || pred_valid_o !== {2{i >= 7}}) begin
        n_bad++;
        $display("FAIL reset_ready edge%0d: rdy=%b pv=%b want %b",
                 i + 1, ready_o, pred_valid_o, i >= 7);
      end
      n_cmp++;
      if (pred_taken_o !== 2'b00 || ghr_o !== 4'h0) begin
        n_bad++;
        $display("FAIL reset_pred: pt=%b ghr=%h want 00/0",
                 pred_taken_o, ghr_o);
      end
    end
  endtask

  task automatic test_history_hash();
    do_reset();
    update_valid_i = 1; update_pc_i = 'h4; update_taken_i = 1;
    vpc_i = 'h4; #1;
    n_cmp++;
    if (pred_taken_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL hash_same_cycle: pt0=%b want 0", pred_taken_o[0]);
    end
    tick(0, 0, 1, 'h4, 1);
    n_cmp++;
    if (ghr_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL hash_ghr: got %b want 0001", ghr_o);
    end
    vpc_i = 'h0; #1;
    n_cmp++;
    if (pred_taken_o !== 2'b01 || pred_taken_o !== m_pred(vpc_i)) begin
      n_bad++;
      $display("FAIL hash_pc0: got %b want 01", pred_taken_o);
    end
    vpc_i = 'h4; #1;
    n_cmp++;
    if (pred_taken_o[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL hash_pc4: got %b want 0", pred_taken_o[0]);
    end
  endtask

  task automatic test_saturation();
    logic [VLEN-1:0] pcs [4];
    bit exp_dn [5];
    logic [VLEN-1:0] pc;
    pcs = '{'h4, 'h0, 'h8, 'h18};
    exp_dn = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 1, pcs[i], 1);
      vpc_i = VLEN'((1 ^ (m_ghr % ROWS)) << 2); #1;
      n_cmp++;
      if (pred_taken_o[0] !== 1'b1 || pred_taken_o !== m_pred(vpc_i)) begin
        n_bad++;
        $display("FAIL sat_up step%0d: got %b want %b", i,
                 pred_taken_o, m_pred(vpc_i));
      end
    end
    n_cmp++;
    if (ghr_o !== 4'b1111) begin
      n_bad++;
      $display("FAIL sat_ghr: got %b want 1111", ghr_o);
    end
    // 3 not-taken then 2 taken on row 1 lane 0: 11->10->01->00->01->10
    for (int i = 0; i < 5; i++) begin
      pc = VLEN'((1 ^ (m_ghr % ROWS)) << 2);
      tick(0, 0, 1, pc, i >= 3);
      vpc_i = VLEN'((1 ^ (m_ghr % ROWS)) << 2); #1;
      n_cmp++;
      if (pred_taken_o[0] !== (i == 4 ? 1'b1 : exp_dn[i])
          || pred_taken_o !== m_pred(vpc_i)) begin
        n_bad++;
        $display("FAIL sat_down step%0d: got %b want %b", i,
                 pred_taken_o, m_pred(vpc_i));
      end
    end
  endtask

  task automatic test_lane();
    do_reset();
    tick(0, 0, 1, 'h6, 1);
    vpc_i = 'h0; #1;
    n_cmp++;
    if (pred_taken_o !== 2'b10 || ghr_o !== 4'b0001) begin
      n_bad++;
      $display("FAIL lane_indep: pt=%b ghr=%b want 10/0001",
               pred_taken_o, ghr_o);
    end
  endtask

  task automatic test_flush();
    tick(0, 1, 1, 'h2, 1);
    n_cmp++;
    if (ready_o !== 1'b0 || ghr_o !== 4'h0) begin
      n_bad++;
      $display("FAIL flush_now: rdy=%b ghr=%h want 0/0", ready_o, ghr_o);
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, '0, 0);
      n_cmp++;
      if (ready_o !== (i == 7) || ghr_o !== 4'h0) begin
        n_bad++;
        $display("FAIL flush_init edge%0d: rdy=%b ghr=%h want %b/0",
                 i + 1, ready_o, ghr_o, i == 7);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      vpc_i = VLEN'(r << 2); #1;
      n_cmp++;
      if (pred_taken_o !== 2'b00) begin
        n_bad++;
        $display("FAIL flush_clear row%0d: got %b want 00", r, pred_taken_o);
      end
    end
  endtask

  task automatic test_init_disturb();
    tick(1, 0, 0, '0, 0);
    for (int c = 0; c < 6; c++) begin
      tick(c == 5, 0, c == 3, 'h4, 1);
      n_cmp++;
      if (ready_o !== 1'b0 || ghr_o !== 4'h0) begin
        n_bad++;
        $display("FAIL init_dist c%0d: rdy=%b ghr=%h want 0/0",
                 c, ready_o, ghr_o);
      end
    end
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 0, '0, 0);
      n_cmp++;
      if (ready_o !== (i == 7)) begin
        n_bad++;
        $display("FAIL init_restart edge%0d: rdy=%b want %b",
                 i + 1, ready_o, i == 7);
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      vpc_i = VLEN'(r << 2); #1;
      n_cmp++;
      if (pred_taken_o !== 2'b00) begin
        n_bad++;
        $display("FAIL init_drop row%0d: got %b want 00", r, pred_taken_o);
      end
    end
  endtask

  task automatic test_random();
    bit f, uv, ut;
    logic [VLEN-1:0] upc;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      vpc_i = VLEN'($urandom_range(0, 255)); #1;
      n_cmp++;
      if (pred_taken_o !== m_pred(vpc_i)) begin
        n_bad++;
        $display("FAIL rand_pred cyc%0d: got %b want %b",
                 i, pred_taken_o, m_pred(vpc_i));
      end
      f = ($urandom_range(0, 49) == 0);
      uv = ($urandom_range(0, 3) != 0);
      ut = $urandom_range(0, 1) == 1;
      upc = VLEN'($urandom_range(0, 255));
      tick(0, f, uv, upc, ut);
      n_cmp++;
      if (ready_o !== m_ready || ghr_o !== HB'(m_ghr)) begin
        n_bad++;
        $display("FAIL rand_state cyc%0d: rdy=%b ghr=%h want %b/%h",
                 i, ready_o, ghr_o, m_ready, m_ghr);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_history_hash();
    test_saturation();
    test_lane();
    test_flush();
    test_init_disturb();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
